// File: rtl/serial_adder_8bit_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package serial_adder_8bit_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_adder_8bit_fa.sv
// One-bit full adder used as the single arithmetic cell of the serial adder.
module full_adder_1bit (
  output logic S,
  output logic Cout,
  input  logic A,
  input  logic B,
  input  logic Cin
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder_8bit.sv
// Bit-serial adder: one full adder, LSB first, WIDTH shift cycles per operation.
// Status outputs busy/done are registered copies of the FSM state.
module serial_adder_8bit
  import serial_adder_8bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             C7,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_sh, b_sh, sum_sh;
  logic               carry;
  logic               c_msb_in;
  logic [CNT_W-1:0]   cnt;
  logic               fa_s, fa_c;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_final;

  full_adder_1bit u_fa (
    .S    (fa_s),
    .Cout (fa_c),
    .A    (a_sh[0]),
    .B    (b_sh[0]),
    .Cin  (carry)
  );

  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign sum_final = {fa_s, sum_sh[WIDTH-1:1]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SHIFT;
      SHIFT:   if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      c_msb_in <= 1'b0;
      cnt      <= '0;
      S        <= '0;
      Cout     <= 1'b0;
      C7       <= 1'b0;
      V        <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state != IDLE);
      done  <= (state == DONE);
      case (state)
        IDLE: begin
          if (start) begin
            a_sh   <= A;
            b_sh   <= B;
            carry  <= Cin;
            sum_sh <= '0;
            cnt    <= '0;
          end
        end
        SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_final;
          carry  <= fa_c;
          cnt    <= cnt + CNT_W'(1);
          // Carry out of the second-to-last bit is the carry into the MSB.
          if (cnt == CNT_W'(WIDTH - 2)) c_msb_in <= fa_c;
          if (last_bit) begin
            S    <= sum_final;
            Cout <= fa_c;
            C7   <= c_msb_in;
            V    <= fa_c ^ c_msb_in;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_8bit.sv
// Scenario-driven bench for serial_adder_8bit with an expected-result queue.
module tb_serial_adder_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] A, B;
  logic       Cin;
  logic [7:0] S;
  logic       Cout, C7, V, busy, done;

  typedef struct {
    logic [7:0] s;
    logic       cout;
    logic       c7;
    logic       v;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  serial_adder_8bit #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cin   (Cin),
    .S     (S),
    .Cout  (Cout),
    .C7    (C7),
    .V     (V),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic ci);
    exp_t e;
    logic [8:0] full;
    logic [7:0] low7;
    full   = {1'b0, a} + {1'b0, b} + {8'd0, ci};
    low7   = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'd0, ci};
    e.s    = full[7:0];
    e.cout = full[8];
    e.c7   = low7[7];
    e.v    = full[8] ^ low7[7];
    return e;
  endfunction

  // Presents operands before an edge; returns #1 after the accepting edge.
  task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic ci);
    @(negedge clk);
    A = a; B = b; Cin = ci; start = 1'b1;
    sb.push_back(model(a, b, ci));
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic collect(input int max_cyc, output logic got, output int lat, output int busy_cnt);
    got = 1'b0; lat = 0; busy_cnt = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; A = 8'hFF; B = 8'hFF; Cin = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (S !== 8'h00)   begin errors++; $display("FAIL reset_S got %h want 00", S); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL reset_Cout got %b want 0", Cout); end
    checks++; if (C7 !== 1'b0)   begin errors++; $display("FAIL reset_C7 got %b want 0", C7); end
    checks++; if (V !== 1'b0)    begin errors++; $display("FAIL reset_V got %b want 0", V); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    logic got; int lat, bc; exp_t e; logic [7:0] s_hold;
    start_op(8'h3C, 8'h25, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_edge0 got %b want 0", busy); end
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL basic_done_seen got %b want 1", got); end
    checks++; if (lat != 9)     begin errors++; $display("FAIL basic_latency got %0d want 9", lat); end
    checks++; if (bc != 9)      begin errors++; $display("FAIL basic_busy_cycles got %0d want 9", bc); end
    checks++; if (S !== e.s)       begin errors++; $display("FAIL basic_S got %h want %h", S, e.s); end
    checks++; if (Cout !== e.cout) begin errors++; $display("FAIL basic_Cout got %b want %b", Cout, e.cout); end
    checks++; if (C7 !== e.c7)     begin errors++; $display("FAIL basic_C7 got %b want %b", C7, e.c7); end
    checks++; if (V !== e.v)       begin errors++; $display("FAIL basic_V got %b want %b", V, e.v); end
    checks++; if (S !== 8'h61)     begin errors++; $display("FAIL basic_S_const got %h want 61", S); end
    s_hold = S;
    @(posedge clk);
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (S !== s_hold) begin errors++; $display("FAIL basic_S_hold got %h want %h", S, s_hold); end
  endtask

  task automatic test_carry;
    logic got; int lat, bc; exp_t e;
    start_op(8'hFF, 8'h01, 1'b0);
    // The previous result must stay visible while the new operation shifts.
    repeat (4) @(posedge clk);
    #1;
    checks++; if (S !== 8'h61) begin errors++; $display("FAIL carry_no_partial got %h want 61", S); end
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (got !== 1'b1)    begin errors++; $display("FAIL carry_done_seen got %b want 1", got); end
    checks++; if (S !== e.s)       begin errors++; $display("FAIL carry_S got %h want %h", S, e.s); end
    checks++; if (Cout !== e.cout) begin errors++; $display("FAIL carry_Cout got %b want %b", Cout, e.cout); end
    checks++; if (C7 !== e.c7)     begin errors++; $display("FAIL carry_C7 got %b want %b", C7, e.c7); end
    checks++; if (V !== e.v)       begin errors++; $display("FAIL carry_V got %b want %b", V, e.v); end
  endtask

  task automatic test_back_to_back;
    logic got; int lat, bc; exp_t e;
    start_op(8'h7F, 8'h01, 1'b0);
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (got !== 1'b1)    begin errors++; $display("FAIL ovf_done_seen got %b want 1", got); end
    checks++; if (S !== e.s)       begin errors++; $display("FAIL ovf_S got %h want %h", S, e.s); end
    checks++; if (Cout !== e.cout) begin errors++; $display("FAIL ovf_Cout got %b want %b", Cout, e.cout); end
    checks++; if (C7 !== e.c7)     begin errors++; $display("FAIL ovf_C7 got %b want %b", C7, e.c7); end
    checks++; if (V !== e.v)       begin errors++; $display("FAIL ovf_V got %b want %b", V, e.v); end
    start_op(8'h80, 8'h80, 1'b1);
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (got !== 1'b1)    begin errors++; $display("FAIL b2b_done_seen got %b want 1", got); end
    checks++; if (lat != 9)        begin errors++; $display("FAIL b2b_latency got %0d want 9", lat); end
    checks++; if (S !== e.s)       begin errors++; $display("FAIL b2b_S got %h want %h", S, e.s); end
    checks++; if (Cout !== e.cout) begin errors++; $display("FAIL b2b_Cout got %b want %b", Cout, e.cout); end
    checks++; if (C7 !== e.c7)     begin errors++; $display("FAIL b2b_C7 got %b want %b", C7, e.c7); end
    checks++; if (V !== e.v)       begin errors++; $display("FAIL b2b_V got %b want %b", V, e.v); end
  endtask

  task automatic test_start_ignored;
    logic got; int lat, bc; exp_t e; int extra;
    start_op(8'h10, 8'h20, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    A = 8'hAA; B = 8'h55; Cin = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL ign_done_seen got %b want 1", got); end
    checks++; if (S !== e.s)    begin errors++; $display("FAIL ign_S got %h want %h", S, e.s); end
    checks++; if (S !== 8'h30)  begin errors++; $display("FAIL ign_S_const got %h want 30", S); end
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin errors++; $display("FAIL ign_second_run got %0d active cycles want 0", extra); end
  endtask

  task automatic test_reset_mid;
    logic got; int lat, bc; exp_t e; int dones;
    start_op(8'h01, 8'h01, 1'b0);
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (S !== e.s) begin errors++; $display("FAIL rmid_pre_S got %h want %h", S, e.s); end
    @(posedge clk);
    #1;
    start_op(8'hF0, 8'h0F, 1'b0);
    void'(sb.pop_front());
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (S !== 8'h00)   begin errors++; $display("FAIL rmid_S got %h want 00", S); end
    checks++; if (Cout !== 1'b0) begin errors++; $display("FAIL rmid_Cout got %b want 0", Cout); end
    checks++; if (C7 !== 1'b0)   begin errors++; $display("FAIL rmid_C7 got %b want 0", C7); end
    checks++; if (V !== 1'b0)    begin errors++; $display("FAIL rmid_V got %b want 0", V); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got %b want 0", done); end
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    checks++; if (dones != 0) begin errors++; $display("FAIL rmid_no_done got %0d pulses want 0", dones); end
    start_op(8'h5A, 8'h33, 1'b1);
    collect(20, got, lat, bc);
    e = sb.pop_front();
    checks++; if (got !== 1'b1)    begin errors++; $display("FAIL rmid_after_done got %b want 1", got); end
    checks++; if (S !== e.s)       begin errors++; $display("FAIL rmid_after_S got %h want %h", S, e.s); end
    checks++; if (Cout !== e.cout) begin errors++; $display("FAIL rmid_after_Cout got %b want %b", Cout, e.cout); end
  endtask

  task automatic test_random;
    logic got; int lat, bc; exp_t e;
    for (int n = 0; n < 8; n++) begin
      start_op(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      collect(20, got, lat, bc);
      e = sb.pop_front();
      checks++;
      if (got !== 1'b1 || S !== e.s || Cout !== e.cout || C7 !== e.c7 || V !== e.v) begin
        errors++;
        $display("FAIL rand_%0d got done=%b S=%h Cout=%b C7=%b V=%b want S=%h Cout=%b C7=%b V=%b",
                 n, got, S, Cout, C7, V, e.s, e.cout, e.c7, e.v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
    test_random();
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder_8bit.md
SERIAL_ADDER_8BIT -- requirements
Module: serial_adder_8bit

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand/result width; the counter sizes from it; all values below assume 8.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port: start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port: A  input  8  augend; captured when start is accepted.
REQ-006 SHALL have port: B  input  8  addend; captured when start is accepted.
REQ-007 SHALL have port: Cin  input  1  carry-in to bit 0; captured when start is accepted.
REQ-008 SHALL have port: S  output  8  registered sum.
REQ-009 SHALL have port: Cout  output  1  carry out of bit 7.
REQ-010 SHALL have port: C7  output  1  carry into bit 7 (carry out of bit 6).
REQ-011 SHALL have port: V  output  1  signed overflow, Cout XOR C7.
REQ-012 SHALL have port: busy  output  1  high while an operation is in progress.
REQ-013 SHALL have port: done  output  1  single-cycle completion pulse.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-015 IDLE with start=1 SHALL capture A, B and Cin into working registers, clear the bit counter, and go to SHIFT; IDLE with start=0 SHALL stay in IDLE.
REQ-016 Each SHIFT cycle SHALL add one bit pair, LSB first, through one full adder: sum bit shifts into the result register from the MSB side; carry-out is registered as the next carry-in.
REQ-017 When the SHIFT cycle processes bit index 6, the carry-out SHALL be latched as C7.
REQ-018 After exactly 8 SHIFT cycles, the FSM SHALL load S, Cout, C7 and V together and go to DONE.
REQ-019 DONE SHALL last exactly one cycle, with done=1, then return to IDLE unconditionally.
REQ-020 Latency: start is accepted at edge 0; done SHALL be high during the cycle following edge 9.
REQ-021 busy SHALL be 1 in SHIFT and DONE, and 0 in IDLE.
REQ-022 start SHALL be ignored in SHIFT and DONE; operands SHALL be re-captured only in IDLE.
REQ-023 S, Cout, C7 and V SHALL hold their last completed values until the next completion; they SHALL NOT show partial results.
REQ-024 Result SHALL equal (A + B + Cin) mod 256; Cout SHALL be bit 8 of the 9-bit sum.
REQ-025 start asserted in the cycle after done SHALL be accepted (no idle gap is required).

Reset
REQ-026 When rst=1 at a rising edge: state SHALL become IDLE; S, Cout, C7, V, busy, done, counter, carry and working registers SHALL all become 0.
REQ-027 rst SHALL override start and any in-progress operation; a reset mid-SHIFT SHALL discard the partial result and produce no done pulse.

Structure
REQ-028 A shared package SHALL hold the FSM state typedef (IDLE/SHIFT/DONE) and the WIDTH default constant.
REQ-029 The one-bit adder SHALL be a sub-module, full_adder_1bit (S, Cout, A, B, Cin), instantiated once.

Verification
REQ-030 A=0x3C, B=0x25, Cin=0 -> S=0x61, Cout=0, C7=0, V=0; done high in the cycle after edge 9; busy high for 9 cycles.
REQ-031 A=0xFF, B=0x01, Cin=0 -> S=0x00, Cout=1, C7=1, V=0.
REQ-032 A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0, C7=1, V=1; then A=0x80, B=0x80, Cin=1 started the cycle after done -> S=0x01, Cout=1, C7=0, V=1.
REQ-033 Start 0x10+0x20; pulse start with 0xAA/0x55 at SHIFT cycle 3 -> S=0x30, single done pulse, second request not executed.
REQ-034 Complete 0x01+0x01 (S=0x02); start 0xF0+0x0F; assert rst at SHIFT cycle 4 -> all outputs 0 next cycle, busy=0, no done pulse; a new start afterwards completes normally.
